// File: rtl/muldiv_pkg.sv
// Shared types and op-class decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_MULW   = 4'd8,
        MD_DIVW   = 4'd9,
        MD_DIVUW  = 4'd10,
        MD_REMW   = 4'd11,
        MD_REMUW  = 4'd12,
        MD_ILL13  = 4'd13,
        MD_ILL14  = 4'd14,
        MD_ILL15  = 4'd15
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_w_op(input md_op_e op);
        return op inside {MD_MULW, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic is_signed_rs1(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW};
    endfunction

    function automatic logic is_signed_rs2(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW};
    endfunction

    // Division class, remainder ops included.
    function automatic logic is_div_op(input md_op_e op);
        return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU, MD_DIVW, MD_DIVUW, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic is_rem_op(input md_op_e op);
        return op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
    endfunction

    function automatic logic is_high_op(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_MULHU};
    endfunction

endpackage

// File: rtl/muldiv_unit_divrem_iter.sv
// Restoring radix-2 divider on unsigned magnitudes; 32 or XLEN iterations per start.
module divrem_iter #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            w_sel,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done_c,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);
    localparam int unsigned CNT_W = $clog2(XLEN);

    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  dsr_q, dsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             act_q, act_d;
    logic [XLEN:0]    rem_sh;
    logic [XLEN:0]    diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            quo_q <= '0;
            rem_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            act_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
            dsr_q <= dsr_d;
            cnt_q <= cnt_d;
            act_q <= act_d;
        end
    end

    // Dividend bits stream out of the top of quo_q while quotient bits shift in below.
    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dsr_d  = dsr_q;
        cnt_d  = cnt_q;
        act_d  = act_q;
        done_c = act_q && (cnt_q == '0);
        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dsr_q};
        if (start) begin
            quo_d = w_sel ? (dividend << (XLEN - 32)) : dividend;
            rem_d = '0;
            dsr_d = divisor;
            cnt_d = w_sel ? CNT_W'(31) : CNT_W'(XLEN - 1);
            act_d = 1'b1;
        end else if (act_q) begin
            rem_d = diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                act_d = 1'b0;
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV64M multiply/divide unit: shift-add multiplier, restoring divider, valid/ready on both sides.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [TAG_W-1:0] in_rd,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_rd,
    output logic             busy
);
    localparam int unsigned     PW    = 2 * XLEN;
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN - 1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = ~XLEN'(32'h7FFF_FFFF);

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return XLEN'($signed(x[31:0]));
    endfunction

    md_state_e        state_q, state_d;
    md_op_e           op_q, op_d;
    logic             w_q, w_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [XLEN-1:0]  mplier_q, mplier_d;
    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_result_q, out_result_d;
    logic [TAG_W-1:0] out_rd_q, out_rd_d;
    logic             busy_q, busy_d;
    logic             in_ready_q, in_ready_d;

    md_op_e           op_c;
    logic             w_c, legal_c, sa_c, sb_c, dz_c, ovf_c, special_c, div_start_c;
    logic [XLEN-1:0]  a_ext_c, b_ext_c, mag_a_c, mag_b_c, spec_res_c;
    logic [PW-1:0]    prod_s_c;
    logic [XLEN-1:0]  quo_s_c, rem_s_c, fix_res_c;
    logic             div_done_c;
    logic [XLEN-1:0]  div_quo, div_rem;

    divrem_iter #(.XLEN(XLEN)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start_c),
        .w_sel     (w_c),
        .dividend  (mag_a_c),
        .divisor   (mag_b_c),
        .done_c    (div_done_c),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Operand prep and the one-cycle special-case result, from the live inputs.
    always_comb begin
        op_c    = md_op_e'(in_op);
        w_c     = (XLEN == 64) && is_w_op(op_c);
        legal_c = (op_c <= MD_REMUW) && (w_c || !is_w_op(op_c));
        a_ext_c = in_rs1;
        b_ext_c = in_rs2;
        if (w_c) begin
            a_ext_c = is_signed_rs1(op_c) ? sext32(in_rs1) : XLEN'(in_rs1[31:0]);
            b_ext_c = is_signed_rs2(op_c) ? sext32(in_rs2) : XLEN'(in_rs2[31:0]);
        end
        sa_c      = is_signed_rs1(op_c) && a_ext_c[XLEN-1];
        sb_c      = is_signed_rs2(op_c) && b_ext_c[XLEN-1];
        mag_a_c   = sa_c ? -a_ext_c : a_ext_c;
        mag_b_c   = sb_c ? -b_ext_c : b_ext_c;
        dz_c      = is_div_op(op_c) && (b_ext_c == '0);
        ovf_c     = is_div_op(op_c) && is_signed_rs1(op_c) && (b_ext_c == '1)
                    && (a_ext_c == (w_c ? MIN_W : MIN_X));
        special_c = !legal_c || dz_c || ovf_c;
        spec_res_c = '0;
        if (legal_c && dz_c) begin
            spec_res_c = is_rem_op(op_c) ? a_ext_c : '1;
        end else if (legal_c && ovf_c) begin
            spec_res_c = is_rem_op(op_c) ? '0 : a_ext_c;
        end
        if (w_c) begin
            spec_res_c = sext32(spec_res_c);
        end
    end

    // Sign correction and result-half selection used in FIX.
    always_comb begin
        prod_s_c = (sa_q ^ sb_q) ? -prod_q : prod_q;
        quo_s_c  = (sa_q ^ sb_q) ? -div_quo : div_quo;
        rem_s_c  = sa_q ? -div_rem : div_rem;
        if (!is_div_op(op_q)) begin
            fix_res_c = is_high_op(op_q) ? prod_s_c[PW-1:XLEN] : prod_s_c[XLEN-1:0];
        end else begin
            fix_res_c = is_rem_op(op_q) ? rem_s_c : quo_s_c;
        end
        if (w_q) begin
            fix_res_c = sext32(fix_res_c);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            op_q         <= MD_MUL;
            w_q          <= 1'b0;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            prod_q       <= '0;
            mcand_q      <= '0;
            mplier_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_rd_q     <= '0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            w_q          <= w_d;
            sa_q         <= sa_d;
            sb_q         <= sb_d;
            prod_q       <= prod_d;
            mcand_q      <= mcand_d;
            mplier_q     <= mplier_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_rd_q     <= out_rd_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        w_d          = w_q;
        sa_d         = sa_q;
        sb_d         = sb_q;
        prod_d       = prod_q;
        mcand_d      = mcand_q;
        mplier_d     = mplier_q;
        out_result_d = out_result_q;
        out_rd_d     = out_rd_q;
        div_start_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    op_d     = op_c;
                    w_d      = w_c;
                    sa_d     = sa_c;
                    sb_d     = sb_c;
                    prod_d   = '0;
                    mcand_d  = PW'(mag_a_c);
                    mplier_d = mag_b_c;
                    out_rd_d = in_rd;
                    if (special_c) begin
                        out_result_d = spec_res_c;
                        state_d      = ST_DONE;
                    end else begin
                        div_start_c = 1'b1;
                        state_d     = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prod_d   = prod_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (div_done_c) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    out_result_d = fix_res_c;
                    state_d      = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        in_ready_d  = (state_d == ST_IDLE);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_rd     = out_rd_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: vector table through a scoreboard plus backpressure, flush and reset sequences.
`timescale 1ns/1ps
module tb_muldiv_unit;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned TAG_W = 5;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV  = 64'h8000_0000_0000_0000;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = 4'd0;
    logic [XLEN-1:0]  in_rs1 = '0;
    logic [XLEN-1:0]  in_rs2 = '0;
    logic [TAG_W-1:0] in_rd = '0;
    logic             flush = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_rd;
    logic             busy;

    muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [63:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one op, wait for its result, compare against the scoreboard, optionally stall the consumer.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd, input logic [63:0] res,
                          input int lat_exp, input int hold);
        exp_t e;
        int   lat;
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_rd    = rd;
        e.res = res;
        e.rd  = rd;
        e.lat = lat_exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = ~op;
        in_rs1   = ~a;
        in_rs2   = ~b;
        in_rd    = ~rd;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
        e = sb.pop_front();
        check({tag, "_latency"}, 64'(lat), 64'(e.lat));
        check({tag, "_result"}, out_result, e.res);
        check({tag, "_rd"}, 64'(out_rd), 64'(e.rd));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_result"}, out_result, e.res);
            check({tag, "_hold_rd"}, 64'(out_rd), 64'(e.rd));
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_hold_busy"}, 64'(busy), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int seen;
        vecs[0]  = '{4'd0,  64'd7,                   ONES - 64'd2,            ONES - 64'd20,           66};
        vecs[1]  = '{4'd3,  ONES,                    ONES,                    ONES - 64'd1,            66};
        vecs[2]  = '{4'd1,  ONES,                    ONES,                    64'd0,                   66};
        vecs[3]  = '{4'd2,  ONES,                    64'd2,                   ONES,                    66};
        vecs[4]  = '{4'd4,  64'd100,                 64'd0,                   ONES,                    1};
        vecs[5]  = '{4'd7,  64'd100,                 64'd0,                   64'd100,                 1};
        vecs[6]  = '{4'd4,  MINV,                    ONES,                    MINV,                    1};
        vecs[7]  = '{4'd6,  MINV,                    ONES,                    64'd0,                   1};
        vecs[8]  = '{4'd9,  64'h1234_5678_FFFF_FFF9, 64'd2,                   ONES - 64'd2,            34};
        vecs[9]  = '{4'd11, 64'h1234_5678_FFFF_FFF9, 64'd2,                   ONES,                    34};
        vecs[10] = '{4'd10, 64'h0000_0000_8000_0000, 64'd1,                   64'hFFFF_FFFF_8000_0000, 34};
        vecs[11] = '{4'd4,  ONES - 64'd99,           64'd7,                   ONES - 64'd13,           66};
        vecs[12] = '{4'd8,  64'hABCD_0000_7FFF_FFFF, 64'h5555_0000_0000_0002, ONES - 64'd1,            34};
        vecs[13] = '{4'd12, 64'h0000_0000_8000_0007, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_8000_0007, 1};
        vecs[14] = '{4'd5,  ONES,                    64'd3,                   64'h5555_5555_5555_5555, 66};
        vecs[15] = '{4'd13, 64'd12,                  64'd3,                   64'd0,                   1};
        vecs[16] = '{4'd9,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_result", out_result, 64'd0);
        check("reset_out_rd", 64'(out_rd), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].rs1, vecs[i].rs2, 5'(i + 1),
                   vecs[i].res, vecs[i].lat, 0);
        end

        // Consumer stalls five cycles, then the next op must still be accepted.
        run_op("backpressure", 4'd0, 64'd6, 64'd7, 5'd9, 64'd42, 66, 5);
        run_op("after_bp", 4'd5, 64'd1000, 64'd10, 5'd3, 64'd100, 66, 0);

        // Flush during CALC drops the op.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd4;
        in_rs1   = 64'd1000;
        in_rs2   = 64'd7;
        in_rd    = 5'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_in_ready", 64'(in_ready), 64'd1);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("flush_no_result", 64'(seen), 64'd0);

        // Flush with in_valid in IDLE must not accept.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        in_op    = 4'd7;
        in_rs2   = 64'd0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        check("idle_flush_busy", 64'(busy), 64'd0);
        check("idle_flush_valid", 64'(out_valid), 64'd0);

        // Reset mid-CALC clears outputs without waiting for a clock.
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd0;
        in_rs1   = 64'd3;
        in_rs2   = 64'd5;
        in_rd    = 5'd11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_result", out_result, 64'd0);
        check("midrst_out_rd", 64'(out_rd), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_reset", 4'd6, ONES - 64'd99, 64'd7, 5'd4, ONES - 64'd1, 66, 0);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV64M multiply/divide unit for the execute stage.
- Replaces single-cycle `*`, `/` and `%` with an iterative radix-2 datapath behind a valid/ready handshake.
- Implements the architectural corner cases: divide-by-zero, signed overflow, and W-variant sign-extension.
- The execute stage issues one op and stalls until the result is accepted for write-back.

Parameters:
- XLEN, 64, datapath width in bits (32 or 64); W ops exist only when XLEN=64.
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  op presented.
- in_ready  out  1  unit can accept an op (state IDLE).
- in_op  in  4  op code (muldiv_pkg::md_op_e).
- in_rs1  in  XLEN  operand 1.
- in_rs2  in  XLEN  operand 2.
- in_rd  in  TAG_W  destination tag.
- flush  in  1  synchronous abort of the in-flight op.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  XLEN  result.
- out_rd  out  TAG_W  tag of the result.
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset (asynchronous): state=IDLE; out_valid=0, out_result=0, out_rd=0, busy=0; all internal registers cleared.
- Op codes:
  - MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
  - MULW=8, DIVW=9, DIVUW=10, REMW=11, REMUW=12.
  - Codes 13–15 are illegal: result 0, taken via the special-case path.
- Accept: occurs when in_valid && in_ready && !flush. Operands, op and rd are latched; the unit moves to CALC, or to DONE for a special case.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
  - CALC: runs N iterations, one per cycle. N = 32 for W ops, else XLEN. A down-counter counts N-1..0.
  - FIX: applies sign correction and selects the result half; takes one cycle.
  - DONE: out_valid=1. out_result and out_rd are held stable until out_ready.
  - DONE with out_ready: goes to IDLE. No new accept occurs in that same cycle, because in_ready is high only in IDLE.
- Latency (accept edge to out_valid high):
  - Normal ops: N+2 cycles (66 for XLEN=64 non-W, 34 for W ops).
  - Special cases: 1 cycle.
- Operand prep:
  - W ops use rs[31:0] only, sign- or zero-extended per op.
  - Signed ops convert operands to magnitudes and record the result signs.
  - MULHSU: rs1 is signed, rs2 is unsigned.
- Multiply:
  - Shift-add over the magnitudes into a 2N-bit product.
  - The product is negated in FIX if the signs differ.
  - MUL/MULW take the low N bits; MULH/MULHSU/MULHU take the high N bits.
- Divide/remainder:
  - Restoring radix-2 algorithm on magnitudes.
  - Quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
- Special cases (skip CALC, go straight to DONE):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = most-negative, divisor = -1): quotient = dividend; remainder = 0.
- W results: the 32-bit result is sign-extended to XLEN. This holds for DIVUW/REMUW too.
- flush:
  - In any non-IDLE state, the unit returns to IDLE next cycle and drops the result; out_valid=0 next cycle.
  - flush with in_valid in IDLE: no accept.
- Reset mid-op: the op is discarded immediately; no partial result reaches the output.

Decomposition:
- Package muldiv_pkg:
  - md_op_e enum and md_state_e enum.
  - Functions is_w_op, is_signed_rs1, is_signed_rs2, is_div_op, is_rem_op, is_high_op.
- Sub-module divrem_iter:
  - Iterative restoring divider on unsigned magnitudes.
  - Interface: start, N-select, done, quotient, remainder.
- The multiplier shift-add stays in the top module.

Test Plan:
- MUL rs1=7, rs2=-3 (0xFFFF_FFFF_FFFF_FFFD) -> out_result=0xFFFF_FFFF_FFFF_FFEB (-21), out_valid at cycle 66, out_rd echoed.
- MULHU rs1=rs2=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands -> 0.
- DIV 100/0 -> 0xFFFF_FFFF_FFFF_FFFF. REMU 100/0 -> 100. DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000. REM of the same pair -> 0. All at 1-cycle latency.
- DIVW rs1=0x1234_5678_FFFF_FFF9 (-7), rs2=2 -> 0xFFFF_FFFF_FFFF_FFFD (-3), latency 34. REMW same -> 0xFFFF_FFFF_FFFF_FFFF. DIVUW rs1=0x8000_0000, rs2=1 -> 0xFFFF_FFFF_8000_0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result/out_rd stable, in_ready=0, busy=1. After out_ready: IDLE next cycle, a new op is accepted.
- flush at CALC cycle 10 -> out_valid never asserts, in_ready=1 next cycle. Reset asserted mid-CALC -> all outputs 0 immediately. The next op after reset completes with the correct result.
